// File: rtl/muldiv_pkg.sv
// Shared types and opcode helpers for the RV32M multiply/divide unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package muldiv_pkg;

   // funct3 encoding of the RV32M instructions
   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction

   // rs1 is treated as two's complement
   function automatic logic is_signed_a(input muldiv_op_e op);
      return op inside {MUL, MULH, MULHSU, DIV, REM};
   endfunction

   // rs2 is treated as two's complement (MULHSU keeps rs2 unsigned)
   function automatic logic is_signed_b(input muldiv_op_e op);
      return op inside {MUL, MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/muldiv_serial_div.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Latency: XLEN cycles after start; done is high during the final iteration cycle.
// Backpressure: none; the owner holds quotient/remainder stable by not restarting.
module muldiv_serial_div #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);
   localparam int CW = $clog2(XLEN);

   logic            busy;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] dvsr;
   logic [XLEN:0]   shifted;
   logic            fits;
   logic [XLEN-1:0] diff;

   // partial remainder shifted left with the next dividend bit (dividend bits live in quotient)
   assign shifted = {remainder, quotient[XLEN-1]};
   assign fits    = (shifted >= {1'b0, dvsr});
   // when the divisor fits the true difference is below dvsr, so XLEN bits suffice
   assign diff    = shifted[XLEN-1:0] - dvsr;
   assign done    = busy && (cnt == CW'(XLEN - 1));

   // load on start, then one restoring step per cycle until XLEN bits are produced
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         cnt       <= '0;
         dvsr      <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy      <= 1'b1;
         cnt       <= '0;
         dvsr      <= divisor;
         quotient  <= dividend;
         remainder <= '0;
      end else if (busy) begin
         remainder <= fits ? diff : shifted[XLEN-1:0];
         quotient  <= {quotient[XLEN-2:0], fits};
         cnt       <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide with RISC-V corner-case results; MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Latency: XLEN+1 edges from accept to valid_o (1 edge for div-by-zero, overflow and fast multiplies).
// Backpressure: ready_o only in IDLE; result held until ready_i, then one idle bubble before the next accept.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_i,
   output logic            ready_o,
   input  muldiv_op_e      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            kill_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o
);
   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state, state_nxt;
   logic [CW-1:0]   cnt;
   muldiv_op_e      op_q;
   logic [XLEN-1:0] a_q, b_q;
   logic            accept, fast_i;
   logic            sa_i, sb_i, sa_q, sb_q;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_done;
   logic [XLEN-1:0] quo, rem;
   logic [2*XLEN-1:0] full;
   logic [XLEN-1:0] res_nxt;

   // divide cases whose result is fixed by the ISA and needs no iteration
   function automatic logic fast_div(input muldiv_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      return (is_div(op) && (b == '0)) ||
             ((op inside {DIV, REM}) && (a == MIN_VAL) && (b == '1));
   endfunction

   assign ready_o = (state == IDLE);
   assign accept  = valid_i && ready_o && !kill_i;
   assign sa_i    = is_signed_a(op_i) && a_i[XLEN-1];
   assign sb_i    = is_signed_b(op_i) && b_i[XLEN-1];
   assign mag_a   = sa_i ? -a_i : a_i;
   assign mag_b   = sb_i ? -b_i : b_i;
   assign sa_q    = is_signed_a(op_q) && a_q[XLEN-1];
   assign sb_q    = is_signed_b(op_q) && b_q[XLEN-1];

   // raw operands and op captured at accept; the inputs are don't-care afterwards
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q <= MUL;
         a_q  <= '0;
         b_q  <= '0;
      end else if (accept) begin
         op_q <= op_i;
         a_q  <= a_i;
         b_q  <= b_i;
      end
   end

   muldiv_serial_div #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (accept && is_div(op_i) && !fast_i),
      .abort     (kill_i),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rem)
   );

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     fa, fb;
   logic signed [2*XLEN+1:0] fprod;

   assign fast_i = !is_div(op_i) || fast_div(op_i, a_i, b_i);
   // one wide signed product from registered operands; the extra top bit carries signedness
   assign fa     = $signed({sa_q, a_q});
   assign fb     = $signed({sb_q, b_q});
   assign fprod  = fa * fb;
   assign full   = fprod[2*XLEN-1:0];
`else
   logic [XLEN-1:0]   mcand;
   logic [2*XLEN-1:0] prod;
   logic [XLEN:0]     psum;

   assign fast_i = fast_div(op_i, a_i, b_i);
   assign psum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mcand : {XLEN{1'b0}})};
   assign full   = (sa_q ^ sb_q) ? -prod : prod;

   // shift-add on magnitudes: multiplier starts in the low half and is consumed LSB first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand <= '0;
         prod  <= '0;
      end else if (accept && !is_div(op_i)) begin
         mcand <= mag_a;
         prod  <= {{XLEN{1'b0}}, mag_b};
      end else if ((state == BUSY) && !is_div(op_q)) begin
         prod <= {psum, prod[XLEN-1:1]};
      end
   end
`endif

   // final result selection with sign fixup and ISA-defined special cases
   always_comb begin
      res_nxt = full[XLEN-1:0];
      if (op_q inside {MULH, MULHSU, MULHU}) begin
         res_nxt = full[2*XLEN-1:XLEN];
      end
      if (is_div(op_q)) begin
         if (b_q == '0) begin
            res_nxt = (op_q inside {DIV, DIVU}) ? '1 : a_q;
         end else if (fast_div(op_q, a_q, b_q)) begin
            res_nxt = (op_q == DIV) ? MIN_VAL : '0;
         end else if (op_q inside {DIV, DIVU}) begin
            res_nxt = (sa_q ^ sb_q) ? -quo : quo;
         end else begin
            res_nxt = sa_q ? -rem : rem;
         end
      end
   end

   // next-state logic; kill overrides everything
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = fast_i ? DONE : BUSY;
         BUSY: if (is_div(op_q) ? div_done : (cnt == CW'(XLEN - 1))) state_nxt = DONE;
         DONE: if (valid_o && ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill_i) begin
         state_nxt = IDLE;
      end
   end

   // state register and iteration counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (kill_i || accept) begin
            cnt <= '0;
         end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // first DONE cycle registers the fixed-up result; it is then held until consumed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_o  <= 1'b0;
         result_o <= '0;
      end else if (kill_i) begin
         valid_o <= 1'b0;
      end else if ((state == DONE) && !valid_o) begin
         valid_o  <= 1'b1;
         result_o <= res_nxt;
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit at XLEN=32: results, latency, handshake, kill and reset.
// Latency: expects XLEN+1 edges for iterative ops, 1 edge for fast paths.
// Backpressure: exercises ready_i held low in DONE.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst_n, valid_i, kill_i, ready_i;
   logic        ready_o, valid_o;
   muldiv_op_e  op_i;
   logic [31:0] a_i, b_i, result_o;
   int          vectors = 0;
   int          miscompares = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .kill_i   (kill_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // drive one request, return after the accept edge with inputs scrambled
   task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      valid_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      op_i    = MULHU;
      a_i     = ~a;
      b_i     = ~b;
   endtask

   // count edges until valid_o, flag ready_o seen high while waiting
   task automatic wait_valid(output int lat, output bit rdy_bad);
      lat     = 0;
      rdy_bad = 1'b0;
      while (!valid_o && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (!valid_o && ready_o) rdy_bad = 1'b1;
      end
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
      chk({tag, "_drop"}, valid_o, 1'b0);
      chk({tag, "_idle"}, ready_o, 1'b1);
   endtask

   task automatic do_op(input string tag, input muldiv_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      bit rdy_bad;
      issue(op, a, b);
      wait_valid(lat, rdy_bad);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_res"}, result_o, exp);
      chk({tag, "_busy"}, rdy_bad, 1'b0);
      consume(tag);
   endtask

   initial begin
      int lat;
      bit rdy_bad, bad;

      rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
      op_i = MUL; a_i = '0; b_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_result", result_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // multiplies
      do_op("mul_7_m3",     MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
      do_op("mul_1234",     MUL,    32'd1234,     32'd5678,      32'd7006652,   MUL_LAT);
      do_op("mulh_min",     MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
      do_op("mulh_m7_3",    MULH,   32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFFF, MUL_LAT);
      do_op("mulhu_max",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
      do_op("mulhu_2p31",   MULHU,  32'h8000_0000, 32'd2,        32'h0000_0001, MUL_LAT);
      do_op("mulhsu_m1",    MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);

      // iterative divides
      do_op("div_m7_2",     DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
      do_op("rem_m7_2",     REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
      do_op("div_7_m2",     DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
      do_op("rem_7_m2",     REM,    32'd7,        32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
      do_op("divu_100_7",   DIVU,   32'd100,      32'd7,         32'd14,        DIV_LAT);
      do_op("remu_100_7",   REMU,   32'd100,      32'd7,         32'd2,         DIV_LAT);
      do_op("divu_max_1",   DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, DIV_LAT);
      do_op("remu_2p31_3",  REMU,   32'h8000_0000, 32'd3,        32'd2,         DIV_LAT);
      do_op("divu_min_max", DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        DIV_LAT);

      // fast paths
      do_op("div_5_0",      DIV,    32'd5,        32'd0,         32'hFFFF_FFFF, 1);
      do_op("divu_5_0",     DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF, 1);
      do_op("remu_42_0",    REMU,   32'd42,       32'd0,         32'd42,        1);
      do_op("rem_m5_0",     REM,    32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1);
      do_op("div_ovf",      DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf",      REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // result held stable under backpressure
      issue(DIVU, 32'd100, 32'd7);
      wait_valid(lat, rdy_bad);
      chk("hold_lat", lat, DIV_LAT);
      bad = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (valid_o !== 1'b1 || result_o !== 32'd14 || ready_o !== 1'b0) bad = 1'b1;
      end
      chk("hold_stable", bad, 1'b0);
      consume("hold");

      // kill in the same cycle as a request: nothing accepted
      @(negedge clk);
      valid_i = 1'b1; kill_i = 1'b1; op_i = DIV; a_i = 32'd5; b_i = 32'd0;
      @(posedge clk);
      #1;
      valid_i = 1'b0; kill_i = 1'b0;
      chk("killreq_ready", ready_o, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("killreq_novalid", valid_o, 1'b0);

      // kill at BUSY cycle 10
      issue(DIVU, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      @(negedge clk);
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      chk("kill_ready", ready_o, 1'b1);
      chk("kill_valid", valid_o, 1'b0);
      bad = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid_o) bad = 1'b1;
      end
      chk("kill_nores", bad, 1'b0);

      // reset in the middle of an operation; result_o holds 14 from earlier
      issue(DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_valid", valid_o, 1'b0);
      chk("midrst_result", result_o, 32'h0);
      chk("midrst_ready", ready_o, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid_o) bad = 1'b1;
      end
      chk("midrst_nopulse", bad, 1'b0);
      do_op("post_rst",     REMU,   32'd100,      32'd7,         32'd2,         DIV_LAT);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
